// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: SNES read path and AVR read/write path share one
// asynchronous SRAM; all strobes, bus direction and access timing live here.
module sram_arbiter #(
  parameter int ADDR_W        = 21,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              snes_mode,
  input  logic              snes_req,
  input  logic [ADDR_W-1:0] snes_addr,
  output logic              snes_ack,
  output logic [DATA_W-1:0] snes_rdata,
  input  logic              avr_req,
  input  logic              avr_we,
  input  logic [ADDR_W-1:0] avr_addr,
  input  logic [DATA_W-1:0] avr_wdata,
  output logic              avr_ack,
  output logic              avr_err,
  output logic [DATA_W-1:0] avr_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [7:0]        debug
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       owner_snes, owner_avr, rej, mode_latched;
  logic       owner_snes_nx, owner_avr_nx, rej_nx, mode_latched_nx;
  logic       grant, grant_wr, capture;
  logic       ce_n_nx, oe_n_nx, we_n_nx, dout_en_nx;
  logic       snes_ack_nx, avr_ack_nx, avr_err_nx;

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    owner_snes_nx   = owner_snes;
    owner_avr_nx    = owner_avr;
    rej_nx          = rej;
    mode_latched_nx = mode_latched;
    grant           = 1'b0;
    grant_wr        = 1'b0;
    capture         = 1'b0;

    case (state)
      IDLE: begin
        mode_latched_nx = snes_mode;
        owner_snes_nx   = 1'b0;
        owner_avr_nx    = 1'b0;
        rej_nx          = 1'b0;
        if (snes_mode) begin
          // SNES has priority; AVR may only read while the SNES owns the cart
          if (snes_req) begin
            owner_snes_nx = 1'b1;
            grant         = 1'b1;
            state_nx      = RD;
            cnt_nx        = CNT_LOAD;
          end else if (avr_req && !avr_we) begin
            owner_avr_nx = 1'b1;
            grant        = 1'b1;
            state_nx     = RD;
            cnt_nx       = CNT_LOAD;
          end else if (avr_req) begin
            owner_avr_nx = 1'b1;
            rej_nx       = 1'b1;
            state_nx     = DONE;
          end
        end else if (avr_req) begin
          owner_avr_nx = 1'b1;
          grant        = 1'b1;
          if (avr_we) begin
            grant_wr = 1'b1;
            state_nx = WR_SETUP;
          end else begin
            state_nx = RD;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      WR_SETUP: begin
        state_nx = WR_PULSE;
        cnt_nx   = CNT_LOAD;
      end
      WR_PULSE: begin
        if (cnt == 4'd0) state_nx = WR_HOLD;
        else             cnt_nx   = cnt - 4'd1;
      end
      WR_HOLD: state_nx = DONE;
      DONE: begin
        owner_snes_nx = 1'b0;
        owner_avr_nx  = 1'b0;
        rej_nx        = 1'b0;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Pad strobes are registered from the next state so they leave the flops glitch-free
    ce_n_nx     = !(state_nx inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
    oe_n_nx     = (state_nx != RD);
    we_n_nx     = (state_nx != WR_PULSE);
    dout_en_nx  = (state_nx inside {WR_SETUP, WR_PULSE, WR_HOLD});
    snes_ack_nx = (state_nx == DONE) && owner_snes_nx;
    avr_ack_nx  = (state_nx == DONE) && owner_avr_nx;
    avr_err_nx  = (state_nx == DONE) && rej_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      owner_snes   <= 1'b0;
      owner_avr    <= 1'b0;
      rej          <= 1'b0;
      mode_latched <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_dout_en <= 1'b0;
      snes_ack     <= 1'b0;
      avr_ack      <= 1'b0;
      avr_err      <= 1'b0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      snes_rdata   <= '0;
      avr_rdata    <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      owner_snes   <= owner_snes_nx;
      owner_avr    <= owner_avr_nx;
      rej          <= rej_nx;
      mode_latched <= mode_latched_nx;
      sram_ce_n    <= ce_n_nx;
      sram_oe_n    <= oe_n_nx;
      sram_we_n    <= we_n_nx;
      sram_dout_en <= dout_en_nx;
      snes_ack     <= snes_ack_nx;
      avr_ack      <= avr_ack_nx;
      avr_err      <= avr_err_nx;
      // Request operands are frozen at grant; later requester changes are ignored
      if (grant)    sram_addr <= owner_snes_nx ? snes_addr : avr_addr;
      if (grant_wr) sram_dout <= avr_wdata;
      if (capture) begin
        if (owner_snes) snes_rdata <= sram_din;
        else            avr_rdata  <= sram_din;
      end
    end
  end

  assign debug = {state, owner_snes, owner_avr, mode_latched, 2'b00};

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter: three instances with access
// lengths 2, 1 and 15 exercised in turn against a behavioural SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int NL = 3;
  localparam int AW = 21;
  localparam int DW = 8;
  localparam int AC [NL] = '{2, 1, 15};

  typedef struct {
    bit            err;
    bit            has_data;
    logic [DW-1:0] data;
    bit            has_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic          reset_n      [NL];
  logic          snes_mode    [NL];
  logic          snes_req     [NL];
  logic [AW-1:0] snes_addr    [NL];
  logic          snes_ack     [NL];
  logic [DW-1:0] snes_rdata   [NL];
  logic          avr_req      [NL];
  logic          avr_we       [NL];
  logic [AW-1:0] avr_addr     [NL];
  logic [DW-1:0] avr_wdata    [NL];
  logic          avr_ack      [NL];
  logic          avr_err      [NL];
  logic [DW-1:0] avr_rdata    [NL];
  logic [AW-1:0] sram_addr    [NL];
  logic [DW-1:0] sram_dout    [NL];
  logic          sram_dout_en [NL];
  logic [DW-1:0] sram_din     [NL];
  logic          sram_ce_n    [NL];
  logic          sram_oe_n    [NL];
  logic          sram_we_n    [NL];
  logic [7:0]    debug        [NL];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit            in_reset     [NL] = '{1'b1, 1'b1, 1'b1};
  logic [DW-1:0] model_snes_rd [NL] = '{8'h00, 8'h00, 8'h00};
  logic [DW-1:0] model_avr_rd  [NL] = '{8'h00, 8'h00, 8'h00};
  int            oe_run [NL] = '{0, 0, 0};
  int            we_run [NL] = '{0, 0, 0};
  exp_t snes_q [$];
  exp_t avr_q  [$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];

  for (genvar g = 0; g < NL; g++) begin : lane
    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC[g])) dut (
      .clk(clk), .reset_n(reset_n[g]), .snes_mode(snes_mode[g]),
      .snes_req(snes_req[g]), .snes_addr(snes_addr[g]), .snes_ack(snes_ack[g]),
      .snes_rdata(snes_rdata[g]), .avr_req(avr_req[g]), .avr_we(avr_we[g]),
      .avr_addr(avr_addr[g]), .avr_wdata(avr_wdata[g]), .avr_ack(avr_ack[g]),
      .avr_err(avr_err[g]), .avr_rdata(avr_rdata[g]), .sram_addr(sram_addr[g]),
      .sram_dout(sram_dout[g]), .sram_dout_en(sram_dout_en[g]), .sram_din(sram_din[g]),
      .sram_ce_n(sram_ce_n[g]), .sram_oe_n(sram_oe_n[g]), .sram_we_n(sram_we_n[g]),
      .debug(debug[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten SRAM locations read back as a fixed address hash
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic void chk(input string name, input int l, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, l, act, exp, cyc);
    end
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    int r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return 21'h1FFFFF;
    return AW'(32'h40 + $urandom_range(0, 15));
  endfunction

  // Asynchronous SRAM device: writes while we_n is low, drives data while oe_n is low
  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (!sram_ce_n[l] && !sram_we_n[l] && sram_dout_en[l]) dev_mem[sram_addr[l]] = sram_dout[l];
      if (!sram_ce_n[l] && !sram_oe_n[l])
        sram_din[l] = dev_mem.exists(sram_addr[l]) ? dev_mem[sram_addr[l]] : dflt(sram_addr[l]);
      else
        sram_din[l] = 8'hEE;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int l = 0; l < NL; l++) begin
      if (in_reset[l]) begin
        oe_run[l] = 0;
        we_run[l] = 0;
      end else begin
        chk("oe_we_overlap", l, 32'(sram_oe_n[l] | sram_we_n[l]), 32'd1);
        chk("dout_en_with_oe", l, 32'(sram_dout_en[l] & ~sram_oe_n[l]), 32'd0);
        chk("ce_with_strobe", l, 32'(sram_ce_n[l] & (~sram_oe_n[l] | ~sram_we_n[l])), 32'd0);
        if (!sram_oe_n[l]) oe_run[l]++;
        else if (oe_run[l] != 0) begin
          chk("oe_width", l, oe_run[l], AC[l]);
          oe_run[l] = 0;
        end
        if (!sram_we_n[l]) we_run[l]++;
        else if (we_run[l] != 0) begin
          chk("we_width", l, we_run[l], AC[l]);
          we_run[l] = 0;
        end

        if (snes_ack[l]) begin
          if (snes_q.size() == 0) chk("snes_ack_unexpected", l, 32'(snes_ack[l]), 32'd0);
          else begin
            e = snes_q.pop_front();
            chk("snes_ack_cycle", l, cyc, e.cyc);
            chk("snes_rdata", l, 32'(snes_rdata[l]), 32'(e.data));
            chk("debug_owner_snes", l, 32'(debug[l][4:2]), 32'b101);
            model_snes_rd[l] = e.data;
          end
        end else begin
          chk("snes_rdata_hold", l, 32'(snes_rdata[l]), 32'(model_snes_rd[l]));
        end

        if (avr_ack[l]) begin
          if (avr_q.size() == 0) chk("avr_ack_unexpected", l, 32'(avr_ack[l]), 32'd0);
          else begin
            e = avr_q.pop_front();
            chk("avr_ack_cycle", l, cyc, e.cyc);
            chk("avr_err", l, 32'(avr_err[l]), 32'(e.err));
            if (e.has_wr) begin
              chk("wr_sram_addr", l, 32'(sram_addr[l]), 32'(e.addr));
              chk("wr_sram_dout", l, 32'(sram_dout[l]), 32'(e.wdata));
            end
            if (e.has_data) begin
              chk("avr_rdata", l, 32'(avr_rdata[l]), 32'(e.data));
              model_avr_rd[l] = e.data;
            end else begin
              chk("avr_rdata_hold", l, 32'(avr_rdata[l]), 32'(model_avr_rd[l]));
            end
          end
        end else begin
          chk("avr_err_idle", l, 32'(avr_err[l]), 32'd0);
          chk("avr_rdata_hold", l, 32'(avr_rdata[l]), 32'(model_avr_rd[l]));
        end
      end
    end
  end

  // Waits for the owner's ack, churning its request operands mid-access
  task automatic wait_ack(input int l, input bit snes, input bit scr);
    bit got = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (snes ? snes_ack[l] : avr_ack[l]) got = 1'b1;
      else if (scr && i >= 2) begin
        if (snes) snes_addr[l] = AW'($urandom);
        else begin
          avr_addr[l]  = AW'($urandom);
          avr_wdata[l] = DW'($urandom);
        end
        snes_mode[l] = 1'($urandom);
      end
    end
    chk(snes ? "snes_ack_timeout" : "avr_ack_timeout", l, 32'(got), 32'd1);
    if (snes) snes_req[l] = 1'b0;
    else      avr_req[l]  = 1'b0;
  endtask

  // kind: 0 mode0 write, 1 mode0 read, 2 mode1 write (rejected), 3 mode1 AVR read,
  // 4 mode1 SNES read, 5 mode1 SNES+AVR read together, 6 mode0 SNES request ignored
  task automatic op(input int l, input int kind, input logic [AW-1:0] a,
                    input logic [AW-1:0] a2, input logic [DW-1:0] d);
    exp_t e, e2;
    int c;
    int A;
    c = cyc;
    A = AC[l];
    e = '{err: 1'b0, has_data: 1'b0, data: '0, has_wr: 1'b0, addr: a, wdata: d, cyc: 0};
    case (kind)
      0: begin
        snes_mode[l] = 1'b0; avr_we[l] = 1'b1; avr_addr[l] = a; avr_wdata[l] = d; avr_req[l] = 1'b1;
        ref_mem[a] = d;
        e.has_wr = 1'b1; e.cyc = c + A + 3;
        avr_q.push_back(e);
        wait_ack(l, 1'b0, 1'b1);
      end
      1, 3: begin
        snes_mode[l] = (kind == 3); avr_we[l] = 1'b0; avr_addr[l] = a; avr_req[l] = 1'b1;
        e.has_data = 1'b1; e.data = ref_rd(a); e.cyc = c + A + 1;
        avr_q.push_back(e);
        wait_ack(l, 1'b0, 1'b1);
      end
      2: begin
        snes_mode[l] = 1'b1; avr_we[l] = 1'b1; avr_addr[l] = a; avr_wdata[l] = d; avr_req[l] = 1'b1;
        e.err = 1'b1; e.cyc = c + 1;
        avr_q.push_back(e);
        wait_ack(l, 1'b0, 1'b1);
      end
      4: begin
        snes_mode[l] = 1'b1; snes_addr[l] = a; snes_req[l] = 1'b1;
        e.has_data = 1'b1; e.data = ref_rd(a); e.cyc = c + A + 1;
        snes_q.push_back(e);
        wait_ack(l, 1'b1, 1'b1);
      end
      5: begin
        snes_mode[l] = 1'b1; snes_addr[l] = a; snes_req[l] = 1'b1;
        avr_we[l] = 1'b0; avr_addr[l] = a2; avr_req[l] = 1'b1;
        e.has_data = 1'b1; e.data = ref_rd(a); e.cyc = c + A + 1;
        snes_q.push_back(e);
        e2 = e; e2.data = ref_rd(a2); e2.cyc = c + 2 * A + 3;
        avr_q.push_back(e2);
        wait_ack(l, 1'b1, 1'b0);
        wait_ack(l, 1'b0, 1'b1);
      end
      default: begin
        snes_mode[l] = 1'b0; snes_addr[l] = a; snes_req[l] = 1'b1;
        repeat (20) begin
          @(negedge clk);
          chk("ignored_strobes", l, 32'({sram_ce_n[l], sram_oe_n[l], sram_we_n[l]}), 32'b111);
        end
        snes_req[l] = 1'b0;
      end
    endcase
    @(negedge clk);
  endtask

  initial begin
    bit got;
    for (int l = 0; l < NL; l++) begin
      reset_n[l] = 1'b0; snes_mode[l] = 1'b0; snes_req[l] = 1'b0; snes_addr[l] = '0;
      avr_req[l] = 1'b0; avr_we[l] = 1'b0; avr_addr[l] = '0; avr_wdata[l] = '0;
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk("rst_strobes", l, 32'({sram_ce_n[l], sram_oe_n[l], sram_we_n[l]}), 32'b111);
      chk("rst_dout_en", l, 32'(sram_dout_en[l]), 32'd0);
      chk("rst_addr", l, 32'(sram_addr[l]), 32'd0);
      chk("rst_dout", l, 32'(sram_dout[l]), 32'd0);
      chk("rst_acks", l, 32'({snes_ack[l], avr_ack[l], avr_err[l]}), 32'd0);
      chk("rst_rdata", l, 32'({snes_rdata[l], avr_rdata[l]}), 32'd0);
      chk("rst_debug", l, 32'(debug[l][4:0]), 32'd0);
      reset_n[l] = 1'b1;
    end
    @(negedge clk);
    for (int l = 0; l < NL; l++) in_reset[l] = 1'b0;

    for (int l = 0; l < NL; l++) begin
      op(l, 0, 21'h1FFFFF, '0, 8'h5A);
      op(l, 1, 21'h1FFFFF, '0, 8'h00);
      op(l, 5, 21'h000123, 21'h1FFFFF, 8'h00);
      op(l, 2, 21'h1FFFFF, '0, 8'hC3);
      op(l, 1, 21'h1FFFFF, '0, 8'h00);
      op(l, 6, 21'h000040, '0, 8'h00);
      for (int i = 0; i < ((l == 0) ? 60 : 15); i++) begin
        int k = $urandom_range(0, 9);
        if (k >= 7) k = k - 7;
        op(l, k, pick_addr(), pick_addr(), DW'($urandom));
      end
    end

    // Reset in the middle of a write pulse abandons the access without an ack
    snes_mode[0] = 1'b0; avr_we[0] = 1'b1; avr_addr[0] = 21'h0BEEF0; avr_wdata[0] = 8'h77;
    avr_req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!sram_we_n[0]) got = 1'b1;
    end
    chk("rst_pulse_reached", 0, 32'(got), 32'd1);
    in_reset[0] = 1'b1;
    reset_n[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_we_n", 0, 32'(sram_we_n[0]), 32'd1);
    chk("rst_mid_dout_en", 0, 32'(sram_dout_en[0]), 32'd0);
    chk("rst_mid_ce_oe", 0, 32'({sram_ce_n[0], sram_oe_n[0]}), 32'b11);
    chk("rst_mid_ack", 0, 32'(avr_ack[0]), 32'd0);
    avr_req[0] = 1'b0;
    @(negedge clk);
    reset_n[0] = 1'b1;
    model_snes_rd[0] = '0;
    model_avr_rd[0]  = '0;
    @(negedge clk);
    in_reset[0] = 1'b0;
    op(0, 0, 21'h000045, '0, 8'h96);
    op(0, 1, 21'h000045, '0, 8'h00);
    op(0, 4, 21'h1FFFFF, '0, 8'h00);

    repeat (5) @(negedge clk);
    chk("snes_q_drained", 0, 32'(snes_q.size()), 32'd0);
    chk("avr_q_drained", 0, 32'(avr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
